// File: rtl/bus_mem_responder_pkg.sv
// Shared bus encodings and the responder FSM state type.
// The mode encodings are also used by the control unit.
package bus_mem_responder_pkg;

   localparam logic BUS_MODE_READ  = 1'b0;
   localparam logic BUS_MODE_WRITE = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Word-aligned and inside the 2**aw word window.
   function automatic logic addr_legal(input logic [31:0] addr, input int aw);
      logic ok;
      ok = (addr[1:0] == 2'b00);
      for (int b = 2; b < 32; b++) begin
         if (b >= aw + 2 && addr[b]) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/bus_mem_responder_array.sv
// Synchronous single-port 32-bit word RAM; the read port registers every cycle.
module bus_mem_array #(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_index,
   input  logic [31:0]           i_wdata,
   output logic [31:0]           o_rdata
);

   logic [31:0] r_mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_index] <= i_wdata;
      o_rdata <= r_mem[i_index];
   end

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side bus responder: one transaction at a time, programmable wait states,
// registered one-cycle response pulses with an error flag for illegal addresses.
module bus_mem_responder
   import bus_mem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH    = 8,
   parameter int READ_LATENCY  = 2,
   parameter int WRITE_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        BUS_start_transaction,
   input  logic        BUS_mode,
   input  logic [31:0] BUS_addr,
   input  logic [31:0] BUS_wdata,
   output logic [31:0] BUS_rdata,
   output logic        BUS_rdata_valid,
   output logic        BUS_write_done,
   output logic        BUS_busy,
   output logic        BUS_err
);

   localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
   localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);

   state_t                r_state, w_next;
   logic [3:0]            r_cnt, w_cnt_next;
   logic                  r_mode, r_legal;
   logic [ADDR_WIDTH-1:0] r_index;
   logic [31:0]           r_wdata;

   logic                  w_in_legal, w_enter_resp, w_we;
   logic                  w_cur_mode, w_cur_legal;
   logic [ADDR_WIDTH-1:0] w_cur_index;
   logic [31:0]           w_cur_wdata, w_ram_rdata;

   assign w_in_legal = addr_legal(BUS_addr, ADDR_WIDTH);

   // A one-cycle latency enters RESP on the acceptance edge itself, so the RAM
   // has to see the live bus rather than the latched copy in that case.
   assign w_cur_mode   = (r_state == IDLE) ? BUS_mode   : r_mode;
   assign w_cur_legal  = (r_state == IDLE) ? w_in_legal : r_legal;
   assign w_cur_index  = (r_state == IDLE) ? BUS_addr[ADDR_WIDTH+1:2] : r_index;
   assign w_cur_wdata  = (r_state == IDLE) ? BUS_wdata  : r_wdata;
   assign w_enter_resp = (w_next == RESP) && (r_state != RESP);
   assign w_we         = w_enter_resp && (w_cur_mode == BUS_MODE_WRITE) && w_cur_legal;

   bus_mem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_index (w_cur_index),
      .i_wdata (w_cur_wdata),
      .o_rdata (w_ram_rdata)
   );

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      case (r_state)
         IDLE: if (BUS_start_transaction) begin
            w_cnt_next = (BUS_mode == BUS_MODE_WRITE) ? WR_LOAD : RD_LOAD;
            w_next     = (w_cnt_next == 4'd0) ? RESP : WAIT;
         end
         WAIT: begin
            w_cnt_next = r_cnt - 4'd1;
            if (w_cnt_next == 4'd0) w_next = RESP;
         end
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_mode  <= BUS_MODE_READ;
         r_legal <= 1'b0;
         r_index <= '0;
         r_wdata <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (r_state == IDLE && BUS_start_transaction) begin
            r_mode  <= BUS_mode;
            r_legal <= w_in_legal;
            r_index <= BUS_addr[ADDR_WIDTH+1:2];
            r_wdata <= BUS_wdata;
         end
      end
   end

   // Response outputs are registered out of RESP; busy holds through the pulse cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         BUS_rdata       <= '0;
         BUS_rdata_valid <= 1'b0;
         BUS_write_done  <= 1'b0;
         BUS_busy        <= 1'b0;
         BUS_err         <= 1'b0;
      end else begin
         BUS_rdata_valid <= (r_state == RESP) && (r_mode == BUS_MODE_READ);
         BUS_write_done  <= (r_state == RESP) && (r_mode == BUS_MODE_WRITE);
         BUS_err         <= (r_state == RESP) && !r_legal;
         if (r_state == RESP && r_mode == BUS_MODE_READ)
            BUS_rdata <= r_legal ? w_ram_rdata : 32'd0;
         if (r_state == IDLE && BUS_start_transaction)
            BUS_busy <= 1'b1;
         else if (BUS_rdata_valid || BUS_write_done)
            BUS_busy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: four latency configurations checked every
// cycle against a transaction-level model, plus hand-computed pulse/data checks.
module tb_bus_mem_responder;

   localparam int NI = 4;
   // instance:             3      2     1     0
   localparam logic [NI-1:0][3:0] RLP = {4'd15, 4'd4, 4'd1, 4'd2};
   localparam logic [NI-1:0][3:0] WLP = {4'd3,  4'd1, 4'd3, 4'd1};

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        st [NI];
   logic        md [NI];
   logic [31:0] ad [NI];
   logic [31:0] wd [NI];
   logic [31:0] rd [NI];
   logic        vl [NI];
   logic        dn [NI];
   logic        bz [NI];
   logic        er [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      bus_mem_responder #(
         .ADDR_WIDTH    (8),
         .READ_LATENCY  (int'(RLP[g])),
         .WRITE_LATENCY (int'(WLP[g]))
      ) u_dut (
         .clk                   (clk),
         .rst_n                 (rst_n),
         .BUS_start_transaction (st[g]),
         .BUS_mode              (md[g]),
         .BUS_addr              (ad[g]),
         .BUS_wdata             (wd[g]),
         .BUS_rdata             (rd[g]),
         .BUS_rdata_valid       (vl[g]),
         .BUS_write_done        (dn[g]),
         .BUS_busy              (bz[g]),
         .BUS_err               (er[g])
      );
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk1(input string nm, input logic got, input logic exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", nm, got, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Transaction-level model: accepted at edge k, response visible after edge k+LAT,
   // a new request only accepted on an edge strictly after the previous response edge.
   int          cyc = 0;
   int          m_k [NI];
   int          m_p [NI];
   bit          m_wr [NI];
   bit          m_ok [NI];
   int          m_idx [NI];
   logic [31:0] m_wdv [NI];
   logic [31:0] m_rdata [NI];
   bit          m_rk [NI];
   logic [31:0] mm [NI][256];
   bit          mk [NI][256];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NI; i++) begin
            m_k[i] = -10; m_p[i] = -1; m_rdata[i] = 32'd0; m_rk[i] = 1'b1;
         end
      end else begin
         cyc++;
         for (int i = 0; i < NI; i++) begin
            if (cyc == m_p[i]) begin
               if (m_wr[i]) begin
                  if (m_ok[i]) begin mm[i][m_idx[i]] = m_wdv[i]; mk[i][m_idx[i]] = 1'b1; end
               end else begin
                  m_rdata[i] = m_ok[i] ? mm[i][m_idx[i]] : 32'd0;
                  m_rk[i]    = !m_ok[i] || mk[i][m_idx[i]];
               end
            end
            if (st[i] && cyc > m_p[i]) begin
               m_k[i]   = cyc;
               m_wr[i]  = md[i];
               m_p[i]   = cyc + int'(md[i] ? WLP[i] : RLP[i]);
               m_ok[i]  = (ad[i] % 4 == 0) && (ad[i] < 32'd1024);
               m_idx[i] = m_ok[i] ? int'(ad[i] / 4) : 0;
               m_wdv[i] = wd[i];
            end
         end
      end
   end

   bit cmp_en = 1'b0;
   always @(negedge clk) begin
      if (rst_n && cmp_en) begin
         for (int i = 0; i < NI; i++) begin
            chk1($sformatf("u%0d.valid", i), vl[i], cyc == m_p[i] && !m_wr[i]);
            chk1($sformatf("u%0d.done", i),  dn[i], cyc == m_p[i] &&  m_wr[i]);
            chk1($sformatf("u%0d.err", i),   er[i], cyc == m_p[i] && !m_ok[i]);
            chk1($sformatf("u%0d.busy", i),  bz[i], m_k[i] <= cyc && cyc <= m_p[i]);
            if (m_rk[i]) chk32($sformatf("u%0d.rdata", i), rd[i], m_rdata[i]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic go(input int i, input logic m, input logic [31:0] a, input logic [31:0] w);
      st[i] = 1'b1; md[i] = m; ad[i] = a; wd[i] = w;
      tick();
      st[i] = 1'b0; md[i] = 1'($urandom); ad[i] = $urandom; wd[i] = $urandom;
   endtask

   // One transaction with hand-supplied latency and expected response.
   task automatic txn(input int i, input logic m, input logic [31:0] a, input logic [31:0] w,
                      input int lat, input logic eerr, input logic [31:0] erd, input string nm);
      go(i, m, a, w);
      for (int t = 1; t < lat; t++) begin
         tick();
         chk1({nm, ".early"}, vl[i] | dn[i], 1'b0);
         chk1({nm, ".busy_wait"}, bz[i], 1'b1);
      end
      tick();
      chk1({nm, ".pulse"}, m ? dn[i] : vl[i], 1'b1);
      chk1({nm, ".other"}, m ? vl[i] : dn[i], 1'b0);
      chk1({nm, ".err"}, er[i], eerr);
      chk1({nm, ".busy_pulse"}, bz[i], 1'b1);
      if (!m) chk32({nm, ".rdata"}, rd[i], erd);
      tick();
      chk1({nm, ".pulse_end"}, vl[i] | dn[i] | er[i], 1'b0);
      chk1({nm, ".busy_end"}, bz[i], 1'b0);
   endtask

   initial begin
      for (int i = 0; i < NI; i++) begin
         st[i] = 1'b0; md[i] = 1'b0; ad[i] = 32'd0; wd[i] = 32'd0;
      end
      #1 rst_n = 1'b0;
      repeat (3) tick();
      for (int i = 0; i < NI; i++) begin
         chk1($sformatf("rst.u%0d.busy", i), bz[i], 1'b0);
         chk1($sformatf("rst.u%0d.resp", i), vl[i] | dn[i] | er[i], 1'b0);
         chk32($sformatf("rst.u%0d.rdata", i), rd[i], 32'd0);
      end
      rst_n = 1'b1;
      cmp_en = 1'b1;
      tick();

      // write then read, default latencies
      txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1, 1'b0, 32'd0, "t1.wr");
      txn(0, 1'b0, 32'h10, 32'd0, 2, 1'b0, 32'hDEADBEEF, "t1.rd");

      // latency sweep
      txn(1, 1'b1, 32'h40, 32'h11110001, 3, 1'b0, 32'd0, "t2.u1.wr");
      txn(1, 1'b0, 32'h40, 32'd0, 1, 1'b0, 32'h11110001, "t2.u1.rd");
      txn(2, 1'b1, 32'h44, 32'h22220002, 1, 1'b0, 32'd0, "t2.u2.wr");
      txn(2, 1'b0, 32'h44, 32'd0, 4, 1'b0, 32'h22220002, "t2.u2.rd");
      txn(3, 1'b1, 32'h48, 32'h33330003, 3, 1'b0, 32'd0, "t2.u3.wr");
      txn(3, 1'b0, 32'h48, 32'd0, 15, 1'b0, 32'h33330003, "t2.u3.rd");

      // illegal addresses; 0x400 would alias word 0 if the range check were missing
      txn(0, 1'b1, 32'h0, 32'h0BADF00D, 1, 1'b0, 32'd0, "t3.wr0");
      txn(0, 1'b0, 32'h13, 32'd0, 2, 1'b1, 32'd0, "t3.rd_misalign");
      txn(0, 1'b1, 32'h400, 32'hFFFFFFFF, 1, 1'b1, 32'd0, "t3.wr_range");
      txn(0, 1'b0, 32'h0, 32'd0, 2, 1'b0, 32'h0BADF00D, "t3.rd0");

      // start during WAIT and RESP is ignored
      txn(0, 1'b1, 32'h20, 32'h12345678, 1, 1'b0, 32'd0, "t4.wr");
      go(0, 1'b0, 32'h20, 32'd0);
      st[0] = 1'b1; md[0] = 1'b1; ad[0] = 32'h20; wd[0] = 32'h55;
      tick();
      chk1("t4.no_early", vl[0] | dn[0], 1'b0);
      tick();
      st[0] = 1'b0;
      chk1("t4.pulse", vl[0], 1'b1);
      chk32("t4.rdata", rd[0], 32'h12345678);
      tick();
      chk1("t4.single", vl[0] | dn[0] | bz[0], 1'b0);
      tick();
      chk1("t4.no_late", vl[0] | dn[0], 1'b0);
      txn(0, 1'b0, 32'h20, 32'd0, 2, 1'b0, 32'h12345678, "t4.rd");

      // back-to-back: start in the pulse cycle is accepted, pulses 3 cycles apart
      go(0, 1'b0, 32'h10, 32'd0);
      tick();
      tick();
      chk1("t5.pulse1", vl[0], 1'b1);
      chk32("t5.rdata1", rd[0], 32'hDEADBEEF);
      go(0, 1'b0, 32'h0, 32'd0);
      chk1("t5.gap1", vl[0], 1'b0);
      chk1("t5.busy_held", bz[0], 1'b1);
      tick();
      chk1("t5.gap2", vl[0], 1'b0);
      tick();
      chk1("t5.pulse2", vl[0], 1'b1);
      chk32("t5.rdata2", rd[0], 32'h0BADF00D);
      tick();
      chk1("t5.busy_end", bz[0], 1'b0);

      // reset during the WAIT of a write drops the write
      txn(1, 1'b1, 32'h8, 32'h00001234, 3, 1'b0, 32'd0, "t6.wr_old");
      go(1, 1'b1, 32'h8, 32'hA5A5A5A5);
      tick();
      chk1("t6.busy_before", bz[1], 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("t6.async_busy", bz[1], 1'b0);
      chk32("t6.async_rdata", rd[1], 32'd0);
      tick();
      tick();
      chk1("t6.no_done", dn[1] | er[1], 1'b0);
      rst_n = 1'b1;
      tick();
      chk1("t6.no_done_after", dn[1], 1'b0);
      txn(1, 1'b0, 32'h8, 32'd0, 1, 1'b0, 32'h00001234, "t6.rd_old");

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
